// File: rtl/lif_neuron_ref_if.sv
// Neuron port bundle: per-timestep synaptic inputs and the neuron's registered outputs.
// The network side uses the master modport and the neuron uses the slave modport.
interface lif_neuron_ref_if #(
  parameter int S  = 8,
  parameter int WW = 5,
  parameter int VW = 8
);
  logic              tick;
  logic [S-1:0]      syn_spike;
  logic [S*WW-1:0]   syn_weight;
  logic              force_spike;
  logic              spike;
  logic [VW-1:0]     v_mem;
  logic              refractory;

  modport master (
    output tick, syn_spike, syn_weight, force_spike,
    input  spike, v_mem, refractory
  );

  modport slave (
    input  tick, syn_spike, syn_weight, force_spike,
    output spike, v_mem, refractory
  );
endinterface

// File: rtl/lif_neuron_ref.sv
// Leaky integrate-and-fire neuron with signed synapses, an optional registered adder stage
// and an absolute refractory period counted in timesteps.
module lif_neuron_ref #(
  parameter int S      = 8,
  parameter int WW     = 5,
  parameter int VW     = 8,
  parameter int V_TH   = 14,
  parameter int V_REST = 6,
  parameter int V_LEAK = 1,
  parameter int K_SYN  = 1,
  parameter int T_REF  = 2,
  parameter int PIPE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  lif_neuron_ref_if.slave bus
);
  localparam int AW = WW + $clog2(S) + 1;
  localparam int EW = VW + AW + 2;
  localparam int RW = (T_REF > 0) ? $clog2(T_REF + 1) : 1;

  localparam logic signed [EW-1:0] C_TH   = EW'(V_TH);
  localparam logic signed [EW-1:0] C_LEAK = EW'(V_LEAK);
  localparam logic signed [EW-1:0] C_K    = EW'(K_SYN);
  localparam logic [VW-1:0]        C_REST = VW'(V_REST);
  localparam logic [RW-1:0]        C_TREF = RW'(T_REF);

  if ((V_TH <= V_REST) || (V_TH > ((2 ** VW) - 1))) begin : g_param_check
    $error("lif_neuron_ref: V_TH must satisfy V_REST < V_TH <= 2^VW-1");
  end

  typedef enum logic [0:0] {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_t;

  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_sum_use;
  logic                 w_force_use;
  logic                 w_upd;
  logic signed [EW-1:0] w_v_nxt;

  state_t        r_state, w_state_nxt;
  logic [VW-1:0] r_v_mem, w_v_mem_nxt;
  logic [RW-1:0] r_ref_cnt, w_ref_cnt_nxt;
  logic          w_fire;
  logic          r_spike;
  logic          r_refr;

  // Signed sum of the weights of all synapses that spiked this timestep.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < S; j++) begin
      if (bus.syn_spike[j]) begin
        w_sum = w_sum + AW'($signed(bus.syn_weight[j*WW +: WW]));
      end else begin
        w_sum = w_sum;
      end
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic signed [AW-1:0] r_sum_q;
    logic                 r_force_q;
    logic                 r_upd;

    // Adder stage: capture the tick's operands; reset drops any tick in flight.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_sum_q   <= '0;
        r_force_q <= 1'b0;
        r_upd     <= 1'b0;
      end else begin
        r_upd <= bus.tick;
        if (bus.tick) begin
          r_sum_q   <= w_sum;
          r_force_q <= bus.force_spike;
        end else begin
          r_sum_q   <= r_sum_q;
          r_force_q <= r_force_q;
        end
      end
    end

    assign w_sum_use   = r_sum_q;
    assign w_force_use = r_force_q;
    assign w_upd       = r_upd;
  end else begin : g_comb
    assign w_sum_use   = w_sum;
    assign w_force_use = bus.force_spike;
    assign w_upd       = bus.tick;
  end

  // Wide enough that neither the gain product nor the leak can wrap.
  assign w_v_nxt = $signed({{(EW-VW){1'b0}}, r_v_mem}) + (C_K * EW'(w_sum_use)) - C_LEAK;

  // Next-state logic for the integrate/refractory machine.
  always_comb begin
    w_state_nxt   = r_state;
    w_v_mem_nxt   = r_v_mem;
    w_ref_cnt_nxt = r_ref_cnt;
    w_fire        = 1'b0;
    if (w_upd) begin
      case (r_state)
        ST_INTEGRATE: begin
          if (w_force_use || (w_v_nxt >= C_TH)) begin
            w_fire      = 1'b1;
            w_v_mem_nxt = C_REST;
            if (T_REF > 0) begin
              w_ref_cnt_nxt = C_TREF;
              w_state_nxt   = ST_REFRACT;
            end else begin
              w_ref_cnt_nxt = '0;
              w_state_nxt   = ST_INTEGRATE;
            end
          end else if (w_v_nxt[EW-1]) begin
            w_v_mem_nxt = '0;
          end else begin
            w_v_mem_nxt = w_v_nxt[VW-1:0];
          end
        end
        ST_REFRACT: begin
          w_v_mem_nxt = C_REST;
          if (w_force_use) begin
            w_fire        = 1'b1;
            w_ref_cnt_nxt = C_TREF;
          end else if (r_ref_cnt <= RW'(1)) begin
            w_ref_cnt_nxt = '0;
            w_state_nxt   = ST_INTEGRATE;
          end else begin
            w_ref_cnt_nxt = r_ref_cnt - RW'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_INTEGRATE;
          w_v_mem_nxt   = C_REST;
          w_ref_cnt_nxt = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, membrane and output registers; refractory tracks the state register exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_INTEGRATE;
      r_v_mem   <= C_REST;
      r_ref_cnt <= '0;
      r_spike   <= 1'b0;
      r_refr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_v_mem   <= w_v_mem_nxt;
      r_ref_cnt <= w_ref_cnt_nxt;
      r_spike   <= w_fire;
      r_refr    <= (w_state_nxt == ST_REFRACT);
    end
  end

  assign bus.spike      = r_spike;
  assign bus.v_mem      = r_v_mem;
  assign bus.refractory = r_refr;
endmodule

// File: tb/tb_lif_neuron_ref.sv
// Scoreboard bench: a PIPE=1 and a PIPE=0 neuron share one stimulus stream; expected
// responses from a timestep-level model are queued and checked on the falling edge.
module tb_lif_neuron_ref;
  localparam int S = 8, WW = 5, VW = 8;
  localparam int V_TH = 14, V_REST = 6, V_LEAK = 1, K_SYN = 1, T_REF = 2;

  typedef struct {
    int   due;
    logic spk;
    int   v;
    logic refr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q [2][$];

  int m_v = V_REST;
  int m_left = 0;
  bit m_in_refr = 1'b0;

  lif_neuron_ref_if #(.S(S), .WW(WW), .VW(VW)) bus0 ();
  lif_neuron_ref_if #(.S(S), .WW(WW), .VW(VW)) bus1 ();

  lif_neuron_ref #(.PIPE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  lif_neuron_ref #(.PIPE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic mon_one(input int k, input logic spk, input logic [VW-1:0] v, input logic refr);
    exp_t e;
    string p;
    p = (k == 0) ? "pipe0" : "pipe1";
    if ((q[k].size() > 0) && (q[k][0].due == cyc)) begin
      e = q[k].pop_front();
      check({p, " spike"}, int'(spk), int'(e.spk));
      check({p, " v_mem"}, int'(v), e.v);
      check({p, " refractory"}, int'(refr), int'(e.refr));
    end else begin
      check({p, " idle_spike"}, int'(spk), 0);
    end
  endtask

  // Monitor: compare each neuron against the head of its queue when an update is due.
  always @(negedge clk) begin
    mon_one(0, bus0.spike, bus0.v_mem, bus0.refractory);
    mon_one(1, bus1.spike, bus1.v_mem, bus1.refractory);
  end

  task automatic set_in(input logic [S-1:0] spk, input logic [S*WW-1:0] w, input logic frc, input logic tk);
    bus0.syn_spike = spk; bus0.syn_weight = w; bus0.force_spike = frc; bus0.tick = tk;
    bus1.syn_spike = spk; bus1.syn_weight = w; bus1.force_spike = frc; bus1.tick = tk;
  endtask

  // Timestep-level reference: one call per tick, plain integer arithmetic.
  task automatic model_step(input logic [S-1:0] spk, input logic [S*WW-1:0] w, input logic frc,
                            output logic fire);
    int sum, n;
    logic signed [WW-1:0] wj;
    sum = 0;
    fire = 1'b0;
    for (int j = 0; j < S; j++) begin
      wj = w[j*WW +: WW];
      if (spk[j]) sum += int'(wj);
    end
    if (m_in_refr) begin
      m_v = V_REST;
      if (frc) begin
        fire = 1'b1;
        m_left = T_REF;
      end else begin
        m_left--;
        if (m_left == 0) m_in_refr = 1'b0;
      end
    end else begin
      n = m_v + K_SYN * sum - V_LEAK;
      if (frc || n >= V_TH) begin
        fire = 1'b1;
        m_v = V_REST;
        if (T_REF > 0) begin
          m_in_refr = 1'b1;
          m_left = T_REF;
        end
      end else if (n < 0) begin
        m_v = 0;
      end else begin
        m_v = n;
      end
    end
  endtask

  task automatic tick_op(input logic [S-1:0] spk, input logic [S*WW-1:0] w, input logic frc);
    exp_t e;
    logic fire;
    set_in(spk, w, frc, 1'b1);
    model_step(spk, w, frc, fire);
    e.spk = fire; e.v = m_v; e.refr = m_in_refr;
    e.due = cyc + 1; q[0].push_back(e);
    e.due = cyc + 2; q[1].push_back(e);
    @(posedge clk); #1;
    set_in('0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Updates committing at or after the first reset edge are lost, so drop their expectations.
  task automatic do_reset(input int n);
    reset = 1'b0;
    set_in('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++)
      while ((q[k].size() > 0) && (q[k][$].due > cyc)) void'(q[k].pop_back());
    m_v = V_REST; m_left = 0; m_in_refr = 1'b0;
    idle(n);
    reset = 1'b1;
  endtask

  task automatic check_rest(input string name);
    check({name, " pipe0 v_mem"}, int'(bus0.v_mem), V_REST);
    check({name, " pipe1 v_mem"}, int'(bus1.v_mem), V_REST);
    check({name, " pipe0 spike"}, int'(bus0.spike), 0);
    check({name, " pipe1 spike"}, int'(bus1.spike), 0);
    check({name, " pipe0 refractory"}, int'(bus0.refractory), 0);
    check({name, " pipe1 refractory"}, int'(bus1.refractory), 0);
  endtask

  function automatic logic [S*WW-1:0] all_w(input int val);
    logic [S*WW-1:0] r;
    for (int j = 0; j < S; j++) r[j*WW +: WW] = WW'(val);
    return r;
  endfunction

  function automatic logic [S*WW-1:0] one_w(input int j0, input int val);
    logic [S*WW-1:0] r;
    r = '0;
    r[j0*WW +: WW] = WW'(val);
    return r;
  endfunction

  initial begin
    logic [S-1:0] rs;
    logic [S*WW-1:0] rw;
    logic rf;
    set_in('0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_reset(3);
    check_rest("reset");
    idle(3);
    check_rest("hold_after_reset");

    // Integrate to threshold, then the refractory window.
    tick_op(8'h01, one_w(0, 3), 1'b0);
    tick_op(8'h01, one_w(0, 3), 1'b0);
    idle(1);
    tick_op(8'h01, one_w(0, 5), 1'b0);
    idle(2);
    tick_op(8'hFF, all_w(15), 1'b0);
    tick_op(8'hFF, all_w(15), 1'b0);
    tick_op(8'h01, one_w(0, 3), 1'b0);
    idle(3);

    // Inhibition clamp and leak down to zero.
    do_reset(1);
    tick_op(8'h01, one_w(0, -10), 1'b0);
    idle(3);
    do_reset(1);
    for (int i = 0; i < 7; i++) tick_op('0, '0, 1'b0);
    idle(3);

    // Largest positive and negative synaptic sums.
    do_reset(1);
    tick_op(8'hFF, all_w(15), 1'b0);
    idle(2);
    do_reset(1);
    tick_op(8'hFF, all_w(-16), 1'b0);
    idle(3);

    // Forced firing, including a re-fire while refractory.
    do_reset(1);
    tick_op('0, '0, 1'b1);
    tick_op('0, '0, 1'b0);
    tick_op('0, '0, 1'b1);
    tick_op(8'hFF, all_w(15), 1'b0);
    tick_op(8'hFF, all_w(15), 1'b0);
    tick_op(8'h01, one_w(0, 3), 1'b0);
    idle(3);

    // Reset between a firing tick and its update.
    do_reset(1);
    tick_op(8'hFF, all_w(15), 1'b0);
    do_reset(1);
    check_rest("midflight_reset");
    idle(3);

    for (int i = 0; i < 400; i++) begin
      rs = S'($urandom());
      for (int j = 0; j < S; j++) rw[j*WW +: WW] = WW'(int'($urandom_range(0, 31)) - 10);
      rf = ($urandom_range(0, 15) == 0);
      tick_op(rs, rw, rf);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 49) == 0) begin
        do_reset($urandom_range(1, 2));
        check_rest("random_reset");
      end
    end

    idle(4);
    check("pipe0 drain", q[0].size(), 0);
    check("pipe1 drain", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_neuron_ref.md
Name: lif_neuron_ref

Overview:
Parametrised leaky integrate-and-fire neuron. It is the next generation of the single-step neuron and adds signed (excitatory/inhibitory) synaptic weights, an explicit timestep strobe, an optional pipelined adder stage and an absolute refractory period driven by a small state machine. One instance sits per neuron in the network array. It takes S synapse spike/weight pairs and emits a one-cycle output spike.

Parameters:
S, 8, number of input synapses (>=1)
WW, 5, synaptic weight width, two's-complement signed
VW, 8, membrane voltage width, unsigned
V_TH, 14, firing threshold; legal range V_REST < V_TH <= 2^VW-1
V_REST, 6, reset/rest potential
V_LEAK, 1, leak subtracted per timestep
K_SYN, 1, synaptic gain, non-negative integer
T_REF, 2, refractory length in timesteps; 0 disables refractory
PIPE, 1, 1 = registered adder stage, 0 = single-cycle update

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
tick  in  1  timestep strobe, one update per tick
syn_spike  in  S  per-synapse spike for this timestep
syn_weight  in  S*WW  packed signed weights; synapse j is at [j*WW +: WW]
force_spike  in  1  force a firing on this timestep
spike  out  1  output spike, one-cycle pulse
v_mem  out  VW  current membrane voltage
refractory  out  1  high while in REFRACT state

Behaviour:
- Reset (reset==0 at a clk edge):
  - v_mem=V_REST, spike=0, refractory=0, state=INTEGRATE, ref_cnt=0.
  - The pipeline valid bit is cleared, so any in-flight tick is dropped.
  - reset takes priority over every other input.
- Synaptic sum:
  - sum = signed sum over j of (syn_spike[j] ? syn_weight[j] : 0).
  - Sum width is AW = WW + clog2(S) + 1, signed; it cannot overflow.
- Stage 0 (PIPE=1):
  - On the tick cycle: sum_q <= sum, force_q <= force_spike, upd <= 1. On any other cycle upd <= 0.
  - syn_* and force_spike are sampled only in the tick cycle.
- Stage 0 (PIPE=0): upd = tick, and sum/force are used combinationally.
- Update event (upd==1): compute v_nxt = v_mem + K_SYN*sum - V_LEAK in signed width VW+AW+2; no intermediate wrap is allowed.
- State INTEGRATE, on an update event:
  - If force or v_nxt >= V_TH: fire, v_mem <= V_REST. If T_REF > 0, ref_cnt <= T_REF and state -> REFRACT.
  - Else if v_nxt < 0: v_mem <= 0.
  - Else: v_mem <= v_nxt[VW-1:0].
- State REFRACT, on an update event:
  - Synaptic input and leak are ignored; v_mem is held at V_REST.
  - If force: fire, ref_cnt reloads to T_REF, stay in REFRACT.
  - Else: ref_cnt decrements. When ref_cnt==1, ref_cnt <= 0 and state -> INTEGRATE.
  - Net effect: exactly T_REF timesteps are ignored after a firing.
- No update event: v_mem, state and ref_cnt hold.
- spike:
  - Registered. It is 1 for exactly the one clk cycle after a firing update event, and 0 otherwise.
  - Back-to-back ticks may each produce a spike pulse.
- Latency from the tick edge to updated v_mem/spike: 1 cycle for PIPE=0, 2 cycles for PIPE=1.
- Throughput: one tick per cycle is accepted in both modes. Consecutive ticks are processed in order, with no stall and no loss.
- refractory is a registered copy of (state==REFRACT).
- Illegal parameters (V_TH <= V_REST, V_TH > 2^VW-1) must be caught by an elaboration-time assertion.

Test Plan:
All scenarios use default parameters, PIPE=1.
- Reset: hold reset=0 for 3 cycles, then release -> v_mem=6, spike=0, refractory=0. No change until the first tick.
- Integrate and fire:
  - Ticks with syn0 weight +3, +3, +5 -> v_mem 8, then 10.
  - Third tick gives 14 -> spike pulse of exactly 1 cycle, 2 cycles after that tick; v_mem=6, refractory=1.
- Refractory: after that firing, 2 ticks with all synapses at weight +15 -> no spike, v_mem=6. The third tick with weight +3 -> v_mem=8, refractory=0.
- Inhibition and leak clamp:
  - From v_mem=6, a tick with weight -10 -> v_mem=0 (raw value -5 is clamped).
  - Idle ticks from 6 -> 5, 4, 3, 2, 1, 0, 0.
- Saturation sum: all 8 synapses at +15 (sum 120) -> fires in one tick, no wrap. All 8 at -16 -> v_mem=0.
- Force and reset corner cases:
  - force_spike with a tick while in REFRACT (ref_cnt=1) -> spike; ref_cnt reloads to 2 and the next 2 ticks are ignored.
  - reset=0 in the cycle between a tick and its update -> no spike, v_mem=6.
  - PIPE=0 rerun of scenario 2 -> spike 1 cycle after the tick.
